tqvp_bus_initiator: RTL
=======================

Name: tqvp_bus_initiator

Overview:
- Initiator (host) side of the TinyQV peripheral bus: drives address, data_in, data_write_n and data_read_n into a peripheral, and collects data_out/data_ready.
- Accepts single read/write commands on a valid/ready command port and returns one response per command on a valid/ready response port.
- Used as the bus driver in peripheral test harnesses and in bridge blocks (e.g. UART-to-peripheral) within the same project.

Parameters:
- TIMEOUT, 16, maximum number of cycles a read strobe is held waiting for data_ready before the read is aborted (legal range 1..255).

Ports:
- clk  in  1  project clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal
- cmd_addr  in  6  peripheral address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  32  read data, zero-extended to size; 0 for writes and errors
- rsp_err  out  1  1 = illegal size or read timeout
- address  out  6  to peripheral
- data_in  out  32  to peripheral
- data_write_n  out  2  to peripheral (11 = idle)
- data_read_n  out  2  to peripheral (11 = idle)
- data_out  in  32  from peripheral
- data_ready  in  1  from peripheral
- user_interrupt  in  1  from peripheral
- irq_rise  out  1  one-cycle pulse on each rising edge of user_interrupt

Behaviour:
- Reset (rst sampled high at an edge):
  - State = IDLE.
  - cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - address=0, data_in=0, data_write_n=11, data_read_n=11, irq_rise=0.
  - Timeout counter cleared; previous-interrupt register cleared to 0.
- Reset asserted mid-transaction: all of the above take effect at that same edge. The in-flight command is dropped and produces no response.
- State machine IDLE, WRITE, READ, RESP. All bus outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On accept with cmd_size=11: go to RESP with rsp_err=1 and rsp_rdata=0. No bus strobe is issued.
  - On accept with cmd_write=1: latch address and data_in; data_write_n=cmd_size; go to WRITE.
  - On accept with cmd_write=0: latch address; data_read_n=cmd_size; clear the counter; go to READ.
- WRITE:
  - Lasts exactly one cycle.
  - Next edge: data_write_n=11, rsp_err=0, rsp_rdata=0, go to RESP.
  - Writes never wait for data_ready.
- READ: strobe held while waiting. At each edge:
  - If data_ready=1: capture data_out masked to size (8-bit keeps [7:0], 16-bit keeps [15:0], upper bits 0). Set rsp_err=0, data_read_n=11, go to RESP.
  - Else, if the counter equals TIMEOUT-1: data_read_n=11, rsp_err=1, rsp_rdata=0, go to RESP.
  - Else: increment the counter.
- RESP:
  - rsp_valid=1 and cmd_ready=0.
  - rsp_rdata and rsp_err are held stable until the handshake.
  - On rsp_valid && rsp_ready: rsp_valid=0, go to IDLE.
  - A new command is accepted no earlier than the cycle after the handshake.
- Latency, with the command accepted at edge N:
  - Strobe is visible during cycle N+1.
  - A write, or a read with data_ready high in cycle N+1, gives rsp_valid from edge N+2.
  - A read whose data_ready never rises times out with rsp_valid from edge N+1+TIMEOUT.
- Idle bus: address and data_in keep their last values, and strobes are 11.
- At most one strobe (read or write) is non-11 at any time.
- cmd_* inputs are ignored outside the accept edge.
- irq_rise = user_interrupt && !previous-interrupt register. The register updates every cycle. irq_rise is independent of the state machine.

Test Plan:
- 32-bit write: addr=0x00, wdata=0xDEADBEEF -> data_write_n=10 for exactly one cycle with address=0, data_in=0xDEADBEEF. rsp_valid two cycles after accept, rsp_err=0.
- 8-bit read: addr=0x04, peripheral data_out=0x123456A5, data_ready=1 -> data_read_n=00 for one cycle, rsp_rdata=0x000000A5, rsp_err=0.
- 16-bit read with data_ready held low 3 cycles, then data_out=0xCAFEF00D -> strobe held 4 cycles, rsp_rdata=0x0000F00D, rsp_err=0.
- Read with data_ready stuck low, TIMEOUT=16 -> strobe held exactly 16 cycles then 11. rsp_err=1, rsp_rdata=0.
- cmd_size=11 -> no strobe ever leaves 11, rsp_err=1. Additionally, hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_err stay stable and cmd_ready stays 0.
- Assert rst during a READ strobe -> data_read_n=11 and rsp_valid=0 at that edge, no response follows. Separately, toggle user_interrupt 0→1→1→0→1 -> irq_rise pulses exactly twice, one cycle each.

Source files
------------

// File: rtl/tqvp_bus_initiator_if.sv
// Command/response handshake and TinyQV peripheral bus signals seen by the
// bus initiator. The master modport is the initiator's view. The slave
// modport is the view of whatever feeds commands and models the peripheral.
interface tqvp_bus_initiator_if;
  // command port
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  // response port
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  // peripheral bus
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;
  logic        irq_rise;

  modport master (
    input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready, user_interrupt,
    output irq_rise
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready, user_interrupt,
    input  irq_rise
  );
endinterface

// File: rtl/tqvp_bus_initiator.sv
// TinyQV peripheral bus initiator. It takes one read or write command at a
// time, drives the registered bus strobes and returns exactly one response
// per command. A rising-edge detector on user_interrupt runs alongside the
// command engine and does not depend on it.
module tqvp_bus_initiator #(
  parameter int TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rst,
  tqvp_bus_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] STROBE_IDLE = 2'b11;
  localparam logic [1:0] SIZE_BAD    = 2'b11;
  localparam logic [7:0] CNT_LAST    = 8'(TIMEOUT - 1);

  state_t      state;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic [5:0]  address_q;
  logic [31:0] data_in_q;
  logic [1:0]  write_n_q;
  logic [1:0]  read_n_q;
  logic [7:0]  wait_cnt;
  logic        irq_prev;
  logic        irq_rise_q;

  // Keep only the bytes covered by the access size; upper bits read as zero.
  function automatic logic [31:0] mask_to_size(input logic [31:0] d,
                                               input logic [1:0]  sz);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {24'd0, d[7:0]};
      2'b01:   r = {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Command engine: accept, strobe the bus, wait for data, hand back a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      address_q   <= 6'd0;
      data_in_q   <= 32'd0;
      write_n_q   <= STROBE_IDLE;
      read_n_q    <= STROBE_IDLE;
      wait_cnt    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            if (bus.cmd_size == SIZE_BAD) begin
              // Illegal size is answered straight away without touching the bus.
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'd0;
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else if (bus.cmd_write) begin
              address_q <= bus.cmd_addr;
              data_in_q <= bus.cmd_wdata;
              write_n_q <= bus.cmd_size;
              state     <= WRITE;
            end else begin
              address_q <= bus.cmd_addr;
              read_n_q  <= bus.cmd_size;
              wait_cnt  <= 8'd0;
              state     <= READ;
            end
          end
        end

        WRITE: begin
          // Writes are posted: one strobe cycle, never wait for data_ready.
          write_n_q   <= STROBE_IDLE;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'd0;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end

        READ: begin
          if (bus.data_ready) begin
            // The held read strobe still encodes the access size.
            rsp_rdata_q <= mask_to_size(bus.data_out, read_n_q);
            rsp_err_q   <= 1'b0;
            read_n_q    <= STROBE_IDLE;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            read_n_q    <= STROBE_IDLE;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'd0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RESP: begin
          // Response fields stay frozen until the consumer takes them.
          cmd_ready_q <= 1'b0;
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          write_n_q   <= STROBE_IDLE;
          read_n_q    <= STROBE_IDLE;
        end
      endcase
    end
  end

  // Interrupt edge detector: one-cycle pulse per rising edge of user_interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev   <= 1'b0;
      irq_rise_q <= 1'b0;
    end else begin
      irq_prev   <= bus.user_interrupt;
      irq_rise_q <= bus.user_interrupt & ~irq_prev;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.address      = address_q;
  assign bus.data_in      = data_in_q;
  assign bus.data_write_n = write_n_q;
  assign bus.data_read_n  = read_n_q;
  assign bus.irq_rise     = irq_rise_q;

endmodule
